// File: rtl/sat_pkg.sv
// Shared literal helpers and state type for the SAT propagation blocks.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package sat_pkg;

   localparam int LIT_WIDTH_DEF = 6;

   typedef enum logic {
      ACTIVE   = 1'b0,
      CONFLICT = 1'b1
   } iq_state_e;

   // Variable index of a literal of width w (sign bit stripped).
   function automatic logic [31:0] lit_var(input logic [31:0] lit, input int w);
      return lit & ((32'd1 << (w - 1)) - 32'd1);
   endfunction

   // Sign of a literal of width w; 1 means the variable is negated.
   function automatic logic lit_sign(input logic [31:0] lit, input int w);
      return lit[w - 1];
   endfunction

endpackage

// File: rtl/lit_fifo.sv
// Generic circular-buffer FIFO for literals, power-of-two depth.
// Latency: a pushed entry is visible at pop_dat the cycle after the push.
// Backpressure: caller must not push when full or pop when empty; clr empties it.
//
// Ports: clk, rst_n (async active-low), clr (sync empty), push/push_dat,
//        pop/pop_dat (head entry), full, empty, count (occupancy).
module lit_fifo #(
   parameter int W     = 6,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop,
   output logic [W-1:0]               pop_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign pop_dat = mem[rd_ptr];
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);

   // Storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push && !clr) mem[wr_ptr] <= push_dat;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/implication_queue.sv
// Classifies forced literals against the assignment table; queues new ones.
// Latency: accepted literal reaches out_lit one cycle later; conflict flags next cycle.
// Backpressure: in_ready low when full (no ready-through) or in conflict; out valid/ready.
//
// Ports: clk, rst_n; in_valid/in_lit/in_ready from the unit detector;
//        out_valid/out_lit/out_ready to the trail; unassign_valid/unassign_var
//        for backtrack; flush (sync clear); conflict/conflict_lit; count.
// Optional: IMPLICATION_QUEUE_STATS_EN adds stat_enq/stat_dup saturating counters.
module implication_queue
   import sat_pkg::*;
#(
   parameter int LIT_WIDTH = LIT_WIDTH_DEF,
   parameter int DEPTH     = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [LIT_WIDTH-1:0]       in_lit,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [LIT_WIDTH-1:0]       out_lit,
   input  logic                       out_ready,
   input  logic                       unassign_valid,
   input  logic [LIT_WIDTH-2:0]       unassign_var,
   input  logic                       flush,
   output logic                       conflict,
   output logic [LIT_WIDTH-1:0]       conflict_lit,
`ifdef IMPLICATION_QUEUE_STATS_EN
   output logic [15:0]                stat_enq,
   output logic [15:0]                stat_dup,
`endif
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int VW       = LIT_WIDTH - 1;
   localparam int NUM_VARS = 2**VW - 1;

   iq_state_e             state;
   logic [NUM_VARS:0]     assigned;
   logic [NUM_VARS:0]     value;
   logic [VW-1:0]         in_var;
   logic                  in_sign;
   logic                  accept;
   logic                  known;
   logic                  is_enq;
   logic                  is_dup;
   logic                  is_conf;
   logic                  full;
   logic                  empty;
   logic                  pop;
   logic [LIT_WIDTH-1:0]  head_lit;

   assign in_var  = VW'(lit_var(32'(in_lit), LIT_WIDTH));
   assign in_sign = lit_sign(32'(in_lit), LIT_WIDTH);

   assign in_ready  = (state == ACTIVE) && !full;
   assign out_valid = (state == ACTIVE) && !empty;
   // Masked so the head reads 0 when nothing is presented (incl. after reset).
   assign out_lit   = out_valid ? head_lit : '0;

   // Variable 0 falls through all three classes and is silently ignored.
   assign accept  = in_valid && in_ready && !flush;
   assign known   = accept && (in_var != '0) && assigned[in_var];
   assign is_enq  = accept && (in_var != '0) && !assigned[in_var];
   assign is_dup  = known && (value[in_var] == !in_sign);
   assign is_conf = known && (value[in_var] == in_sign);
   assign pop     = out_valid && out_ready && !flush;

   lit_fifo #(
      .W     (LIT_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (flush),
      .push     (is_enq),
      .push_dat (in_lit),
      .pop      (pop),
      .pop_dat  (head_lit),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   // Set is written after the unassign so a same-variable set wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         assigned <= '0;
         value    <= '0;
      end else if (flush) begin
         assigned <= '0;
      end else begin
         if (unassign_valid) assigned[unassign_var] <= 1'b0;
         if (is_enq) begin
            assigned[in_var] <= 1'b1;
            value[in_var]    <= !in_sign;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ACTIVE;
         conflict     <= 1'b0;
         conflict_lit <= '0;
      end else if (flush) begin
         state        <= ACTIVE;
         conflict     <= 1'b0;
         conflict_lit <= '0;
      end else if (is_conf) begin
         state        <= CONFLICT;
         conflict     <= 1'b1;
         conflict_lit <= in_lit;
      end
   end

`ifdef IMPLICATION_QUEUE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_enq <= '0;
         stat_dup <= '0;
      end else if (flush) begin
         stat_enq <= '0;
         stat_dup <= '0;
      end else begin
         if (is_enq && (stat_enq != 16'hFFFF)) stat_enq <= stat_enq + 16'd1;
         if (is_dup && (stat_dup != 16'hFFFF)) stat_dup <= stat_dup + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_implication_queue.sv
// Bench for implication_queue: directed scenarios plus a randomized run,
// all checked against a queue/table reference model kept in this file.
module tb_implication_queue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [5:0] in_lit;
   logic       in_ready;
   logic       out_valid;
   logic [5:0] out_lit;
   logic       out_ready;
   logic       unassign_valid;
   logic [4:0] unassign_var;
   logic       flush;
   logic       conflict;
   logic [5:0] conflict_lit;
   logic [3:0] count;
`ifdef IMPLICATION_QUEUE_STATS_EN
   logic [15:0] stat_enq;
   logic [15:0] stat_dup;
`endif

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: queue of literals, table 0=unassigned,1=true,2=false.
   logic [5:0] m_q[$];
   int         m_tab[32];
   bit         m_conf;
   logic [5:0] m_clit;
   int         m_enq;
   int         m_dup;

   always #5 clk = ~clk;

   implication_queue dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_lit         (in_lit),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .out_lit        (out_lit),
      .out_ready      (out_ready),
      .unassign_valid (unassign_valid),
      .unassign_var   (unassign_var),
      .flush          (flush),
      .conflict       (conflict),
      .conflict_lit   (conflict_lit),
`ifdef IMPLICATION_QUEUE_STATS_EN
      .stat_enq       (stat_enq),
      .stat_dup       (stat_dup),
`endif
      .count          (count)
   );

   task automatic model_clear();
      m_q.delete();
      foreach (m_tab[i]) m_tab[i] = 0;
      m_conf = 1'b0;
      m_clit = '0;
      m_enq  = 0;
      m_dup  = 0;
   endtask

   function automatic bit m_ready();
      return !m_conf && (m_q.size() < 8);
   endfunction

   function automatic bit m_ovld();
      return !m_conf && (m_q.size() > 0);
   endfunction

   function automatic logic [5:0] m_head();
      return m_ovld() ? m_q[0] : 6'h00;
   endfunction

   // Apply one clock's worth of the rules to the model using current inputs.
   task automatic model_step();
      bit rdy, ovld;
      int v, want, cur;
      if (flush) begin
         model_clear();
         return;
      end
      rdy  = m_ready();
      ovld = m_ovld();
      v    = int'(in_lit[4:0]);
      want = in_lit[5] ? 2 : 1;
      cur  = m_tab[v];
      if (ovld && out_ready) void'(m_q.pop_front());
      if (unassign_valid) m_tab[unassign_var] = 0;
      if (in_valid && rdy && v != 0) begin
         if (cur == 0) begin
            m_q.push_back(in_lit);
            m_tab[v] = want;
            if (m_enq < 65535) m_enq++;
         end else if (cur == want) begin
            if (m_dup < 65535) m_dup++;
         end else begin
            m_conf = 1'b1;
            m_clit = in_lit;
         end
      end
   endtask

   task automatic cyc(input bit iv, input logic [5:0] il, input bit ordy,
                      input bit uv, input logic [4:0] uvar, input bit fl);
      in_valid       = iv;
      in_lit         = il;
      out_ready      = ordy;
      unassign_valid = uv;
      unassign_var   = uvar;
      flush          = fl;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 0; in_lit = '0; out_ready = 0;
      unassign_valid = 0; unassign_var = '0; flush = 0;
      rst_n = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      in_valid = 0; in_lit = '0; out_ready = 0;
      unassign_valid = 0; unassign_var = '0; flush = 0;
      rst_n = 1'b0;
      model_clear();
      #3;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++; if (out_lit !== 6'h00) begin miscompares++; $display("FAIL reset_out_lit got %h want 00", out_lit); end
      vectors++; if (conflict !== 1'b0) begin miscompares++; $display("FAIL reset_conflict got %b want 0", conflict); end
      vectors++; if (conflict_lit !== 6'h00) begin miscompares++; $display("FAIL reset_conflict_lit got %h want 00", conflict_lit); end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_order();
      do_reset();
      cyc(1, 6'h03, 1, 0, 0, 0);
      vectors++; if (out_valid !== 1'b1 || out_lit !== 6'h03) begin miscompares++; $display("FAIL order_first got v=%b lit=%h want v=1 lit=03", out_valid, out_lit); end
      cyc(1, 6'h05, 1, 0, 0, 0);
      vectors++; if (out_valid !== 1'b1 || out_lit !== 6'h05) begin miscompares++; $display("FAIL order_second got v=%b lit=%h want v=1 lit=05", out_valid, out_lit); end
      vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL order_pushpop_count got %0d want 1", count); end
      cyc(0, 6'h00, 1, 0, 0, 0);
      vectors++; if (count !== 4'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL order_drained got count=%0d v=%b want 0 0", count, out_valid); end
   endtask

   task automatic test_duplicate();
      do_reset();
      cyc(1, 6'h03, 0, 0, 0, 0);
      cyc(1, 6'h03, 0, 0, 0, 0);
      vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL dup_count got %0d want 1", count); end
`ifdef IMPLICATION_QUEUE_STATS_EN
      vectors++; if (stat_enq !== 16'd1) begin miscompares++; $display("FAIL dup_stat_enq got %0d want 1", stat_enq); end
      vectors++; if (stat_dup !== 16'd1) begin miscompares++; $display("FAIL dup_stat_dup got %0d want 1", stat_dup); end
`endif
      // Flush beats a simultaneous accept.
      cyc(1, 6'h06, 0, 0, 0, 1);
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL dup_flush_priority got %0d want 0", count); end
   endtask

   task automatic test_conflict();
      do_reset();
      cyc(1, 6'h03, 0, 0, 0, 0);
      cyc(1, 6'h23, 0, 0, 0, 0);
      vectors++; if (conflict !== 1'b1 || conflict_lit !== 6'h23) begin miscompares++; $display("FAIL conf_flag got %b/%h want 1/23", conflict, conflict_lit); end
      vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL conf_handshake got rdy=%b v=%b want 0 0", in_ready, out_valid); end
      cyc(1, 6'h05, 1, 0, 0, 0);
      vectors++; if (count !== 4'd1 || conflict !== 1'b1) begin miscompares++; $display("FAIL conf_hold got count=%0d conf=%b want 1 1", count, conflict); end
      cyc(0, 6'h00, 0, 0, 0, 1);
      vectors++; if (conflict !== 1'b0 || conflict_lit !== 6'h00) begin miscompares++; $display("FAIL conf_flush got %b/%h want 0/00", conflict, conflict_lit); end
      vectors++; if (count !== 4'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL conf_flush_q got count=%0d rdy=%b want 0 1", count, in_ready); end
      cyc(1, 6'h23, 0, 0, 0, 0);
      vectors++; if (count !== 4'd1 || conflict !== 1'b0) begin miscompares++; $display("FAIL conf_table_cleared got count=%0d conf=%b want 1 0", count, conflict); end
   endtask

   task automatic test_full_wrap();
      logic [5:0] l;
      do_reset();
      for (int i = 1; i <= 8; i++) cyc(1, 6'(i), 0, 0, 0, 0);
      vectors++; if (count !== 4'd8 || in_ready !== 1'b0) begin miscompares++; $display("FAIL full_state got count=%0d rdy=%b want 8 0", count, in_ready); end
      cyc(1, 6'h09, 1, 0, 0, 0);
      vectors++; if (count !== 4'd7 || in_ready !== 1'b1) begin miscompares++; $display("FAIL full_pop got count=%0d rdy=%b want 7 1", count, in_ready); end
      for (int i = 2; i <= 8; i++) begin
         vectors++; if (out_lit !== 6'(i)) begin miscompares++; $display("FAIL drain0_order got %h want %h", out_lit, 6'(i)); end
         cyc(0, 6'h00, 1, 0, 0, 0);
      end
      for (int r = 0; r < 2; r++) begin
         for (int k = 1; k <= 8; k++) begin
            l = {r[0] ? 1'b0 : 1'b1, 5'(8 * r + 8 + k)};
            cyc(1, l, 0, 0, 0, 0);
         end
         vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL wrap_fill round %0d got %0d want 8", r, count); end
         for (int k = 1; k <= 8; k++) begin
            l = {r[0] ? 1'b0 : 1'b1, 5'(8 * r + 8 + k)};
            vectors++; if (out_valid !== 1'b1 || out_lit !== l) begin miscompares++; $display("FAIL wrap_order round %0d got %h want %h", r, out_lit, l); end
            cyc(0, 6'h00, 1, 0, 0, 0);
         end
      end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL wrap_empty got %0d want 0", count); end
   endtask

   task automatic test_unassign();
      do_reset();
      cyc(1, 6'h04, 0, 0, 0, 0);
      cyc(0, 6'h00, 0, 1, 5'd4, 0);
      cyc(1, 6'h24, 0, 0, 0, 0);
      vectors++; if (count !== 4'd2 || conflict !== 1'b0) begin miscompares++; $display("FAIL unassign_reenq got count=%0d conf=%b want 2 0", count, conflict); end
      vectors++; if (out_lit !== 6'h04) begin miscompares++; $display("FAIL unassign_keeps_queue got %h want 04", out_lit); end
      // Set and unassign of the same variable together: the set wins.
      cyc(1, 6'h07, 0, 1, 5'd7, 0);
      cyc(1, 6'h27, 0, 0, 0, 0);
      vectors++; if (conflict !== 1'b1 || conflict_lit !== 6'h27) begin miscompares++; $display("FAIL set_wins got %b/%h want 1/27", conflict, conflict_lit); end
   endtask

   task automatic test_var0_and_reset();
      do_reset();
      cyc(1, 6'h20, 0, 0, 0, 0);
      cyc(1, 6'h00, 0, 0, 0, 0);
      vectors++; if (count !== 4'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL var0_ignored got count=%0d v=%b want 0 0", count, out_valid); end
      for (int i = 1; i <= 5; i++) cyc(1, 6'(i + 10), 0, 0, 0, 0);
      vectors++; if (count !== 4'd5) begin miscompares++; $display("FAIL pre_reset_count got %0d want 5", count); end
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      vectors++; if (count !== 4'd0 || out_valid !== 1'b0 || out_lit !== 6'h00) begin miscompares++; $display("FAIL async_reset_q got count=%0d v=%b lit=%h want 0 0 00", count, out_valid, out_lit); end
      vectors++; if (in_ready !== 1'b1 || conflict !== 1'b0) begin miscompares++; $display("FAIL async_reset_ctl got rdy=%b conf=%b want 1 0", in_ready, conflict); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(0, 6'h00, 1, 0, 0, 0);
      vectors++; if (count !== 4'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_empty got count=%0d v=%b want 0 0", count, out_valid); end
   endtask

   task automatic test_random();
      logic [5:0] l;
      logic [4:0] uv;
      do_reset();
      for (int n = 0; n < 800; n++) begin
         l  = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 11))};
         uv = 5'($urandom_range(0, 11));
         cyc($urandom_range(0, 9) < 7, l, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, uv, $urandom_range(0, 24) == 0);
         vectors++; if (in_ready !== m_ready()) begin miscompares++; $display("FAIL rand_in_ready cyc %0d got %b want %b", n, in_ready, m_ready()); end
         vectors++; if (out_valid !== m_ovld()) begin miscompares++; $display("FAIL rand_out_valid cyc %0d got %b want %b", n, out_valid, m_ovld()); end
         vectors++; if (out_lit !== m_head()) begin miscompares++; $display("FAIL rand_out_lit cyc %0d got %h want %h", n, out_lit, m_head()); end
         vectors++; if (count !== 4'(m_q.size())) begin miscompares++; $display("FAIL rand_count cyc %0d got %0d want %0d", n, count, m_q.size()); end
         vectors++; if (conflict !== m_conf || conflict_lit !== m_clit) begin miscompares++; $display("FAIL rand_conflict cyc %0d got %b/%h want %b/%h", n, conflict, conflict_lit, m_conf, m_clit); end
`ifdef IMPLICATION_QUEUE_STATS_EN
         vectors++; if (stat_enq !== 16'(m_enq) || stat_dup !== 16'(m_dup)) begin miscompares++; $display("FAIL rand_stats cyc %0d got %0d/%0d want %0d/%0d", n, stat_enq, stat_dup, m_enq, m_dup); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_duplicate();
      test_conflict();
      test_full_wrap();
      test_unassign();
      test_var0_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired before the bench completed");
      $fatal(1);
   end

endmodule
